// File: rtl/assemble_pack_pkg.sv
// Shared constants and types for the assemble_pack board-state packetiser.
// Packet layout (MSB first): header, player x/y, three wave rows,
// three 40-bit wave bitfields, XOR checksum byte.
package assemble_pack_pkg;

  localparam int unsigned PACKET_W        = 176;
  localparam int unsigned PAYLOAD_BYTES   = 21;
  localparam int unsigned PAYLOAD_W       = PAYLOAD_BYTES * 8;
  localparam logic [7:0]  HEADER_DEFAULT  = 8'hA5;

  // Field positions inside the 176-bit packet
  localparam int unsigned HEADER_MSB   = 175;
  localparam int unsigned HEADER_LSB   = 168;
  localparam int unsigned PLAYER_X_MSB = 167;
  localparam int unsigned PLAYER_X_LSB = 160;
  localparam int unsigned PLAYER_Y_MSB = 159;
  localparam int unsigned PLAYER_Y_LSB = 152;
  localparam int unsigned WAVE1_Y_MSB  = 151;
  localparam int unsigned WAVE1_Y_LSB  = 144;
  localparam int unsigned WAVE2_Y_MSB  = 143;
  localparam int unsigned WAVE2_Y_LSB  = 136;
  localparam int unsigned WAVE3_Y_MSB  = 135;
  localparam int unsigned WAVE3_Y_LSB  = 128;
  localparam int unsigned WAVE1_BF_MSB = 127;
  localparam int unsigned WAVE1_BF_LSB = 88;
  localparam int unsigned WAVE2_BF_MSB = 87;
  localparam int unsigned WAVE2_BF_LSB = 48;
  localparam int unsigned WAVE3_BF_MSB = 47;
  localparam int unsigned WAVE3_BF_LSB = 8;
  localparam int unsigned CHECKSUM_MSB = 7;
  localparam int unsigned CHECKSUM_LSB = 0;

  // Everything above the checksum byte, byte 20 = header
  typedef logic [PAYLOAD_BYTES-1:0][7:0] payload_t;

  // Saturate a coordinate to limit-1 when it reaches or exceeds limit
  function automatic logic [7:0] clamp_coord(input logic [7:0] value,
                                             input logic [7:0] limit);
    logic [7:0] result;
    if (value >= limit) begin
      result = limit - 8'd1;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/pack_checksum.sv
// Combinational XOR reduction of the 21-byte payload down to one byte.
module pack_checksum
  import assemble_pack_pkg::*;
(
  input  payload_t   payload,
  output logic [7:0] checksum
);

  // Fold every payload byte into a single XOR byte
  always_comb begin
    checksum = 8'h00;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      checksum = checksum ^ payload[i];
    end
  end

endmodule

// File: rtl/assemble_pack.sv
// Registers a coherent 176-bit snapshot of the game board for the UART
// screen printer, with header byte, XOR checksum and a change pulse.
// Optional build macro: ASSEMBLE_PACK_CLAMP_EN saturates coordinates to
// the board size before packing (bitfields are never altered).
module assemble_pack
  import assemble_pack_pkg::*;
#(
  parameter logic [7:0] HEADER  = HEADER_DEFAULT,
  parameter int unsigned BOARD_W = 40,
  parameter int unsigned BOARD_H = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          player_x,
  input  logic [7:0]          player_y,
  input  logic [7:0]          wave1_y,
  input  logic [7:0]          wave2_y,
  input  logic [7:0]          wave3_y,
  input  logic [BOARD_W-1:0]  wave1_bitfield,
  input  logic [BOARD_W-1:0]  wave2_bitfield,
  input  logic [BOARD_W-1:0]  wave3_bitfield,
  output logic [PACKET_W-1:0] packet,
  output logic                packet_updated
);

`ifdef ASSEMBLE_PACK_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic [7:0] X_LIMIT = 8'(BOARD_W);
  localparam logic [7:0] Y_LIMIT = 8'(BOARD_H);
  localparam logic [PACKET_W-1:0] RESET_PACKET = {HEADER, 160'h0, HEADER};

  logic [7:0]          player_x_s;
  logic [7:0]          player_y_s;
  logic [7:0]          wave1_y_s;
  logic [7:0]          wave2_y_s;
  logic [7:0]          wave3_y_s;
  payload_t            payload_s;
  logic [7:0]          checksum_s;
  logic [PACKET_W-1:0] next_packet_s;
  logic [PACKET_W-1:0] packet_r;
  logic                packet_updated_r;

  // Select raw or board-clamped coordinates for packing
  always_comb begin
    player_x_s = player_x;
    player_y_s = player_y;
    wave1_y_s  = wave1_y;
    wave2_y_s  = wave2_y;
    wave3_y_s  = wave3_y;
    if (CLAMP_EN) begin
      player_x_s = clamp_coord(player_x, X_LIMIT);
      player_y_s = clamp_coord(player_y, Y_LIMIT);
      wave1_y_s  = clamp_coord(wave1_y,  Y_LIMIT);
      wave2_y_s  = clamp_coord(wave2_y,  Y_LIMIT);
      wave3_y_s  = clamp_coord(wave3_y,  Y_LIMIT);
    end else begin
      player_x_s = player_x;
      player_y_s = player_y;
      wave1_y_s  = wave1_y;
      wave2_y_s  = wave2_y;
      wave3_y_s  = wave3_y;
    end
  end

  // Assemble the payload from the values sampled on this edge
  always_comb begin
    payload_s = {HEADER, player_x_s, player_y_s, wave1_y_s, wave2_y_s,
                 wave3_y_s, wave1_bitfield, wave2_bitfield, wave3_bitfield};
  end

  pack_checksum u_checksum (
    .payload  (payload_s),
    .checksum (checksum_s)
  );

  // Complete next packet: payload plus its checksum from the same sample
  always_comb begin
    next_packet_s = {payload_s, checksum_s};
  end

  // Snapshot register and change-detect pulse; reset wins over any load
  always_ff @(posedge clk) begin
    if (rst) begin
      packet_r         <= RESET_PACKET;
      packet_updated_r <= 1'b0;
    end else begin
      packet_r         <= next_packet_s;
      packet_updated_r <= (next_packet_s != packet_r);
    end
  end

  assign packet         = packet_r;
  assign packet_updated = packet_updated_r;

endmodule

// File: tb/tb_assemble_pack.sv
// Directed, table-driven bench for assemble_pack plus a short
// back-to-back update sequence. Expected packets are hand-computed.
module tb_assemble_pack;

  logic         clk;
  logic         rst;
  logic [7:0]   player_x, player_y, wave1_y, wave2_y, wave3_y;
  logic [39:0]  wave1_bitfield, wave2_bitfield, wave3_bitfield;
  logic [175:0] packet;
  logic         packet_updated;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic         rst;
    logic [7:0]   px, py, w1y, w2y, w3y;
    logic [39:0]  b1, b2, b3;
    logic [175:0] exp_packet;
    logic         exp_updated;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  localparam logic [175:0] RESET_PKT = {8'hA5, 160'h0, 8'hA5};
  localparam logic [175:0] DEF_PKT =
    {8'hA5, 8'h0A, 8'h01, 8'h12, 8'h12, 8'h12, {15{8'hFF}}, 8'h43};
  localparam logic [175:0] W1_PKT =
    {8'hA5, 8'h0A, 8'h01, 8'h12, 8'h12, 8'h12,
     40'h0000000001, {10{8'hFF}}, 8'hBD};
`ifdef ASSEMBLE_PACK_CLAMP_EN
  localparam logic [175:0] OOR_PKT =
    {8'hA5, 8'h27, 8'h01, 8'h12, 8'h12, 8'h13, {15{8'hFF}}, 8'h6F};
  localparam logic [175:0] EDGE_PKT =
    {8'hA5, 8'h27, 8'h13, 8'h12, 8'h12, 8'h12, {15{8'hFF}}, 8'h7C};
`else
  localparam logic [175:0] OOR_PKT =
    {8'hA5, 8'h50, 8'h01, 8'h12, 8'h12, 8'hFF, {15{8'hFF}}, 8'hF4};
  localparam logic [175:0] EDGE_PKT =
    {8'hA5, 8'h28, 8'h14, 8'h12, 8'h12, 8'h12, {15{8'hFF}}, 8'h74};
`endif

  assemble_pack dut (
    .clk            (clk),
    .rst            (rst),
    .player_x       (player_x),
    .player_y       (player_y),
    .wave1_y        (wave1_y),
    .wave2_y        (wave2_y),
    .wave3_y        (wave3_y),
    .wave1_bitfield (wave1_bitfield),
    .wave2_bitfield (wave2_bitfield),
    .wave3_bitfield (wave3_bitfield),
    .packet         (packet),
    .packet_updated (packet_updated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_vec(input int idx, input logic r,
                         input logic [7:0] px, input logic [7:0] py,
                         input logic [7:0] w1y, input logic [7:0] w2y,
                         input logic [7:0] w3y, input logic [39:0] b1,
                         input logic [39:0] b2, input logic [39:0] b3,
                         input logic [175:0] ep, input logic eu);
    vecs[idx].rst = r;
    vecs[idx].px = px;   vecs[idx].py = py;
    vecs[idx].w1y = w1y; vecs[idx].w2y = w2y; vecs[idx].w3y = w3y;
    vecs[idx].b1 = b1;   vecs[idx].b2 = b2;   vecs[idx].b3 = b3;
    vecs[idx].exp_packet = ep;
    vecs[idx].exp_updated = eu;
  endtask

  task automatic check_pkt(input string name, input logic [175:0] exp);
    tests_run++;
    if (packet !== exp) begin
      tests_failed++;
      $display("FAIL %s packet got %h expected %h", name, packet, exp);
    end
  endtask

  task automatic check_upd(input string name, input logic exp);
    tests_run++;
    if (packet_updated !== exp) begin
      tests_failed++;
      $display("FAIL %s packet_updated got %b expected %b", name, packet_updated, exp);
    end
  endtask

  initial begin
    // idx rst  px     py     w1y    w2y    w3y    b1              b2              b3              expected
    set_vec(0,  1'b1, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 40'h123456789A, 40'hFFFF0000FF, 40'h00000000AA, RESET_PKT, 1'b0);
    set_vec(1,  1'b1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 40'hAAAAAAAAAA, 40'h5555555555, 40'h0F0F0F0F0F, RESET_PKT, 1'b0);
    set_vec(2,  1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, RESET_PKT, 1'b0);
    set_vec(3,  1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 40'h0,          40'h0,          40'h0,          RESET_PKT, 1'b0);
    set_vec(4,  1'b0, 8'h0A, 8'h01, 8'h12, 8'h12, 8'h12, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, DEF_PKT,   1'b1);
    set_vec(5,  1'b0, 8'h0A, 8'h01, 8'h12, 8'h12, 8'h12, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, DEF_PKT,   1'b0);
    set_vec(6,  1'b0, 8'h0A, 8'h01, 8'h12, 8'h12, 8'h12, 40'h0000000001, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, W1_PKT,    1'b1);
    set_vec(7,  1'b0, 8'h0A, 8'h01, 8'h12, 8'h12, 8'h12, 40'h0000000001, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, W1_PKT,    1'b0);
    set_vec(8,  1'b1, 8'h0B, 8'h02, 8'h12, 8'h12, 8'h12, 40'h0000000003, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, RESET_PKT, 1'b0);
    set_vec(9,  1'b0, 8'h0A, 8'h01, 8'h12, 8'h12, 8'h12, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, DEF_PKT,   1'b1);
    set_vec(10, 1'b0, 8'h50, 8'h01, 8'h12, 8'h12, 8'hFF, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, OOR_PKT,   1'b1);
    set_vec(11, 1'b0, 8'h28, 8'h14, 8'h12, 8'h12, 8'h12, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, EDGE_PKT,  1'b1);
    set_vec(12, 1'b0, 8'h28, 8'h14, 8'h12, 8'h12, 8'h12, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF, EDGE_PKT,  1'b0);

    // Table: drive, clock once, sample 1 time unit after the edge
    for (int i = 0; i < NVEC; i++) begin
      rst            = vecs[i].rst;
      player_x       = vecs[i].px;
      player_y       = vecs[i].py;
      wave1_y        = vecs[i].w1y;
      wave2_y        = vecs[i].w2y;
      wave3_y        = vecs[i].w3y;
      wave1_bitfield = vecs[i].b1;
      wave2_bitfield = vecs[i].b2;
      wave3_bitfield = vecs[i].b3;
      @(posedge clk);
      #1;
      check_pkt($sformatf("vec%0d", i), vecs[i].exp_packet);
      check_upd($sformatf("vec%0d", i), vecs[i].exp_updated);
    end

    // Back-to-back differing loads: one pulse per edge, no gaps.
    // Base bytes A5 28 14 12 12 12 xor to 0x8B; wave1/wave3 add 10 FF bytes (cancel).
    // wave2 value 0x0000000001..03 contributes its low byte to the checksum.
    for (int k = 1; k <= 3; k++) begin
      logic [39:0]  w2;
      logic [7:0]   cs;
      logic [175:0] exp;
      w2 = 40'(k);
      cs = 8'h8B ^ w2[7:0];
`ifdef ASSEMBLE_PACK_CLAMP_EN
      cs = 8'h83 ^ w2[7:0];
      exp = {8'hA5, 8'h27, 8'h13, 8'h12, 8'h12, 8'h12, 40'hFFFFFFFFFF, w2, 40'hFFFFFFFFFF, cs};
`else
      exp = {8'hA5, 8'h28, 8'h14, 8'h12, 8'h12, 8'h12, 40'hFFFFFFFFFF, w2, 40'hFFFFFFFFFF, cs};
`endif
      wave2_bitfield = w2;
      @(posedge clk);
      #1;
      check_pkt($sformatf("b2b%0d", k), exp);
      check_upd($sformatf("b2b%0d", k), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/assemble_pack.md
Name: assemble_pack

Overview:
- Serialises the game-board state (player position, three drone-wave rows and their 40-column occupancy bitfields) into one 176-bit framed packet.
- The packet carries a header byte and an XOR checksum byte.
- Sits between the game-logic registers and the UART screen printer, which consumes `packet` as a byte stream, MSB byte first.
- Output is registered, so the printer always sees one coherent snapshot.

Parameters:
- HEADER, 8'hA5, framing byte placed in packet byte 21.
- BOARD_W, 40, board width in columns; also the bitfield width.
- BOARD_H, 20, board height in rows; used only by the optional clamp.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- player_x  input  8  player column.
- player_y  input  8  player row.
- wave1_y  input  8  row of drone wave 1.
- wave2_y  input  8  row of drone wave 2.
- wave3_y  input  8  row of drone wave 3.
- wave1_bitfield  input  40  wave 1 occupancy; bit i = column i occupied.
- wave2_bitfield  input  40  wave 2 occupancy.
- wave3_bitfield  input  40  wave 3 occupancy.
- packet  output  176  framed snapshot (layout below).
- packet_updated  output  1  one-cycle pulse when `packet` changes value.

Behaviour:
- Layout, MSB first:
  - [175:168] HEADER
  - [167:160] player_x
  - [159:152] player_y
  - [151:144] wave1_y
  - [143:136] wave2_y
  - [135:128] wave3_y
  - [127:88] wave1_bitfield
  - [87:48] wave2_bitfield
  - [47:8] wave3_bitfield
  - [7:0] checksum
- Checksum = bitwise XOR of bytes [175:8] (21 bytes, header included).
- All inputs are sampled on the same rising edge. `packet` updates one cycle after the inputs (latency 1). The checksum is computed from the same sampled values, so a packet is never torn.
- Inputs are treated as asynchronous-free (already in the clk domain); no input synchroniser is required.
- Reset (rst=1 at an edge):
  - packet = {HEADER, 160'h0, HEADER}, i.e. checksum equals HEADER.
  - packet_updated = 0.
- Reset has priority over everything, including mid-stream updates. The first post-reset edge loads live inputs.
- packet_updated:
  - Registered.
  - 1 for exactly one cycle at the edge where the newly loaded packet differs from the previous registered value; otherwise 0.
  - Never 1 on the reset edge.
  - Consecutive differing loads produce consecutive pulses.
- No handshake. The consumer may read `packet` at any time.
- No arithmetic beyond XOR. Widths are fixed; out-of-range coordinates pass through unchanged (unless the clamp below is enabled).

Optional Feature:
- Macro: ASSEMBLE_PACK_CLAMP_EN.
- Defined: before packing, saturate each coordinate:
  - player_x to BOARD_W-1 if ≥ BOARD_W.
  - player_y, wave1_y, wave2_y and wave3_y to BOARD_H-1 if ≥ BOARD_H.
  - The checksum and change detection use the clamped values.
  - Bitfields are untouched.
- Undefined: coordinates are packed raw.

Decomposition:
- Package assemble_pack_pkg holds:
  - PACKET_W=176, HEADER_DEFAULT=8'hA5.
  - Field MSB/LSB constants for each field.
  - A typedef for the 21-byte payload.
- One sub-module, pack_checksum: a combinational XOR reduction of a 168-bit vector to 8 bits. It is instantiated once.

Test Plan:
- Reset: hold rst for 3 cycles with arbitrary inputs -> packet = A5, 20×00, A5; packet_updated = 0.
- Release reset with all inputs 0 -> packet unchanged (A5, zeros, A5); packet_updated stays 0.
- Load game defaults (player_x=10, player_y=1, all wave_y=18, all bitfields=40'hFFFFFFFFFF), then one edge ->
  - packet = A5 0A 01 12 12 12, then 15×FF, then checksum 43.
  - packet_updated pulses once.
  - Further identical cycles produce no pulse.
- Change wave1_bitfield to 40'h0000000001 -> bytes [127:88] = 00 00 00 00 01; checksum recomputed = 0xBD; single pulse.
- Assert rst on the same edge an input changes -> reset value wins; no pulse.
- With ASSEMBLE_PACK_CLAMP_EN: player_x=0x50, wave3_y=0xFF -> packed as 0x27 and 0x13. Without the macro -> 0x50 and 0xFF.
